// File: rtl/tl_client_arbiter.sv
// tl_client_arbiter: N-client TileLink A-channel round-robin arbiter with burst locking and D-channel source routing
//
// Ports:
//   clk_i, rst_i (asynchronous, active-high)
//   cli_a_*  : packed per-client A channels in, per-client ready out
//   mgr_a_*  : single registered A channel toward the manager; source is {client index, client source}
//   mgr_d_*  : D channel from the manager
//   cli_d_*  : D fields broadcast to all clients, valid steered by the source's client-index bits
//   stat_grants_o : per-client completed-message counters, present only with TL_CLIENT_ARBITER_STATS_EN defined
module tl_client_arbiter #(
   parameter int N_CLIENTS = 4,
   parameter int ADDR_W    = 64,
   parameter int DATA_W    = 64,
   parameter int SOURCE_W  = 4,
   parameter int CID_W     = $clog2(N_CLIENTS)
) (
   input  logic                            clk_i,
   input  logic                            rst_i,
   input  logic [N_CLIENTS-1:0]            cli_a_valid_i,
   output logic [N_CLIENTS-1:0]            cli_a_ready_o,
   input  logic [N_CLIENTS*3-1:0]          cli_a_opcode_i,
   input  logic [N_CLIENTS*3-1:0]          cli_a_param_i,
   input  logic [N_CLIENTS*4-1:0]          cli_a_size_i,
   input  logic [N_CLIENTS*SOURCE_W-1:0]   cli_a_source_i,
   input  logic [N_CLIENTS*ADDR_W-1:0]     cli_a_address_i,
   input  logic [N_CLIENTS*DATA_W/8-1:0]   cli_a_mask_i,
   input  logic [N_CLIENTS*DATA_W-1:0]     cli_a_data_i,
   input  logic [N_CLIENTS-1:0]            cli_a_corrupt_i,
   output logic                            mgr_a_valid_o,
   input  logic                            mgr_a_ready_i,
   output logic [2:0]                      mgr_a_opcode_o,
   output logic [2:0]                      mgr_a_param_o,
   output logic [3:0]                      mgr_a_size_o,
   output logic [SOURCE_W+CID_W-1:0]       mgr_a_source_o,
   output logic [ADDR_W-1:0]               mgr_a_address_o,
   output logic [DATA_W/8-1:0]             mgr_a_mask_o,
   output logic [DATA_W-1:0]               mgr_a_data_o,
   output logic                            mgr_a_corrupt_o,
   input  logic                            mgr_d_valid_i,
   output logic                            mgr_d_ready_o,
   input  logic [2:0]                      mgr_d_opcode_i,
   input  logic [1:0]                      mgr_d_param_i,
   input  logic [3:0]                      mgr_d_size_i,
   input  logic [SOURCE_W+CID_W-1:0]       mgr_d_source_i,
   input  logic [3:0]                      mgr_d_sink_i,
   input  logic                            mgr_d_denied_i,
   input  logic [DATA_W-1:0]               mgr_d_data_i,
   input  logic                            mgr_d_corrupt_i,
   output logic [N_CLIENTS-1:0]            cli_d_valid_o,
   input  logic [N_CLIENTS-1:0]            cli_d_ready_i,
   output logic [2:0]                      cli_d_opcode_o,
   output logic [1:0]                      cli_d_param_o,
   output logic [3:0]                      cli_d_size_o,
   output logic [SOURCE_W-1:0]             cli_d_source_o,
   output logic [3:0]                      cli_d_sink_o,
   output logic                            cli_d_denied_o,
   output logic                            cli_d_corrupt_o,
   output logic [DATA_W-1:0]               cli_d_data_o
`ifdef TL_CLIENT_ARBITER_STATS_EN
   ,output logic [N_CLIENTS*32-1:0]        stat_grants_o
`endif
);
   localparam int MASK_W = DATA_W / 8;
   localparam int LG     = $clog2(MASK_W);
   localparam logic [N_CLIENTS-1:0] ONE = {{(N_CLIENTS-1){1'b0}}, 1'b1};
   typedef enum logic {IDLE, BURST} state_t;
   state_t state_q, state_d;
   logic [15:0] cnt_q, cnt_d, beats;
   logic [CID_W-1:0] rr_q, rr_d, lock_q, lock_d, gnt;
   logic gnt_v, accept, fire, last;
   logic [2:0] op, sz_unused;
   logic [3:0] sz;
   logic slot_v_q;
   logic [2:0] opcode_q, param_q;
   logic [3:0] size_q;
   logic [SOURCE_W+CID_W-1:0] source_q;
   logic [ADDR_W-1:0] address_q;
   logic [MASK_W-1:0] mask_q;
   logic [DATA_W-1:0] data_q;
   logic corrupt_q;
   logic [CID_W-1:0] d_idx;
   logic d_hit;
   assign sz_unused = 3'b0;
   // While bursting the grant is pinned to the locked client; otherwise scan forward from rr_q.
   always_comb begin
      gnt   = lock_q;
      gnt_v = 1'b0;
      if (state_q == BURST) gnt_v = cli_a_valid_i[lock_q];
      else
         for (int k = 1; k <= N_CLIENTS; k++)
            if (!gnt_v && cli_a_valid_i[(int'(rr_q) + k) % N_CLIENTS]) begin
               gnt_v = 1'b1;
               gnt   = CID_W'((int'(rr_q) + k) % N_CLIENTS);
            end
   end
   assign accept = !slot_v_q || mgr_a_ready_i;
   assign fire   = gnt_v && accept;
   assign op     = cli_a_opcode_i[3*gnt +: 3];
   assign sz     = cli_a_size_i[4*gnt +: 4];
   // Puts carry 2^size bytes spread over MASK_W-byte beats; everything else is one beat.
   assign beats  = (op[2:1] == 2'b00 && sz > 4'(LG)) ? 16'd1 << (sz - 4'(LG)) : 16'd1;
   assign last   = (state_q == BURST) ? (cnt_q == 16'd1) : (beats == 16'd1);
   assign cli_a_ready_o = (fire && !rst_i) ? ONE << gnt : '0;
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      rr_d    = rr_q;
      lock_d  = lock_q;
      if (fire) begin
         if (last) begin
            state_d = IDLE;
            cnt_d   = 16'd0;
            rr_d    = gnt;
         end else if (state_q == IDLE) begin
            state_d = BURST;
            cnt_d   = beats - 16'd1;
            lock_d  = gnt;
         end else cnt_d = cnt_q - 16'd1;
      end
   end
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_q   <= IDLE;
         cnt_q     <= '0;
         rr_q      <= CID_W'(N_CLIENTS - 1);
         lock_q    <= '0;
         slot_v_q  <= 1'b0;
         opcode_q  <= '0;
         param_q   <= '0;
         size_q    <= '0;
         source_q  <= '0;
         address_q <= '0;
         mask_q    <= '0;
         data_q    <= '0;
         corrupt_q <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         rr_q    <= rr_d;
         lock_q  <= lock_d;
         if (accept) slot_v_q <= fire;
         if (fire) begin
            opcode_q  <= op;
            param_q   <= cli_a_param_i[3*gnt +: 3];
            size_q    <= sz;
            source_q  <= {gnt, cli_a_source_i[SOURCE_W*gnt +: SOURCE_W]};
            address_q <= cli_a_address_i[ADDR_W*gnt +: ADDR_W];
            mask_q    <= cli_a_mask_i[MASK_W*gnt +: MASK_W];
            data_q    <= cli_a_data_i[DATA_W*gnt +: DATA_W];
            corrupt_q <= cli_a_corrupt_i[gnt];
         end
      end
   end
   assign mgr_a_valid_o   = slot_v_q;
   assign mgr_a_opcode_o  = opcode_q;
   assign mgr_a_param_o   = param_q;
   assign mgr_a_size_o    = size_q;
   assign mgr_a_source_o  = source_q;
   assign mgr_a_address_o = address_q;
   assign mgr_a_mask_o    = mask_q;
   assign mgr_a_data_o    = data_q;
   assign mgr_a_corrupt_o = corrupt_q;
`ifdef TL_CLIENT_ARBITER_STATS_EN
   logic [31:0] stat_q [N_CLIENTS];
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) for (int k = 0; k < N_CLIENTS; k++) stat_q[k] <= '0;
      else if (fire && last) stat_q[gnt] <= stat_q[gnt] + 32'd1;
   end
   for (genvar i = 0; i < N_CLIENTS; i++) begin : g_stat
      assign stat_grants_o[32*i +: 32] = stat_q[i];
   end
`endif
   // Client indices beyond N_CLIENTS have no owner: the beat is acknowledged and dropped.
   assign d_idx           = mgr_d_source_i[SOURCE_W+CID_W-1 -: CID_W];
   assign d_hit           = {1'b0, d_idx} < (CID_W+1)'(N_CLIENTS);
   assign cli_d_valid_o   = (d_hit && mgr_d_valid_i) ? ONE << d_idx : '0;
   assign mgr_d_ready_o   = d_hit ? cli_d_ready_i[d_idx] : 1'b1;
   assign cli_d_opcode_o  = mgr_d_opcode_i;
   assign cli_d_param_o   = mgr_d_param_i;
   assign cli_d_size_o    = mgr_d_size_i;
   assign cli_d_source_o  = mgr_d_source_i[SOURCE_W-1:0];
   assign cli_d_sink_o    = mgr_d_sink_i;
   assign cli_d_denied_o  = mgr_d_denied_i;
   assign cli_d_corrupt_o = mgr_d_corrupt_i;
   assign cli_d_data_o    = mgr_d_data_i;
endmodule

// File: tb/tb_tl_client_arbiter.sv
// tb_tl_client_arbiter: directed self-checking bench for tl_client_arbiter
module tb_tl_client_arbiter;
   localparam int N = 4, AW = 64, DW = 64, SW = 4, MSW = 6, MW = 8;
   logic clk = 1'b0, rst = 1'b1;
   logic [N-1:0] cli_a_valid = '0, cli_a_ready, cli_a_corrupt = '0;
   logic [N*3-1:0] cli_a_opcode = '0, cli_a_param = '0;
   logic [N*4-1:0] cli_a_size = '0;
   logic [N*SW-1:0] cli_a_source = '0;
   logic [N*AW-1:0] cli_a_address = '0;
   logic [N*MW-1:0] cli_a_mask = '0;
   logic [N*DW-1:0] cli_a_data = '0;
   logic mgr_a_valid, mgr_a_ready = 1'b1, mgr_a_corrupt;
   logic [2:0] mgr_a_opcode, mgr_a_param;
   logic [3:0] mgr_a_size;
   logic [MSW-1:0] mgr_a_source;
   logic [AW-1:0] mgr_a_address;
   logic [MW-1:0] mgr_a_mask;
   logic [DW-1:0] mgr_a_data;
   logic mgr_d_valid = 1'b0, mgr_d_ready, mgr_d_denied = 1'b0, mgr_d_corrupt = 1'b0;
   logic [2:0] mgr_d_opcode = '0;
   logic [1:0] mgr_d_param = '0;
   logic [3:0] mgr_d_size = '0, mgr_d_sink = '0;
   logic [MSW-1:0] mgr_d_source = '0;
   logic [DW-1:0] mgr_d_data = '0;
   logic [N-1:0] cli_d_valid, cli_d_ready = '0;
   logic [2:0] cli_d_opcode;
   logic [1:0] cli_d_param;
   logic [3:0] cli_d_size, cli_d_sink;
   logic [SW-1:0] cli_d_source;
   logic cli_d_denied, cli_d_corrupt;
   logic [DW-1:0] cli_d_data;
`ifdef TL_CLIENT_ARBITER_STATS_EN
   logic [N*32-1:0] stat_grants;
`endif
   int passed = 0, total = 0;
   tl_client_arbiter #(.N_CLIENTS(N), .ADDR_W(AW), .DATA_W(DW), .SOURCE_W(SW)) dut (
      .clk_i(clk), .rst_i(rst),
      .cli_a_valid_i(cli_a_valid), .cli_a_ready_o(cli_a_ready),
      .cli_a_opcode_i(cli_a_opcode), .cli_a_param_i(cli_a_param), .cli_a_size_i(cli_a_size),
      .cli_a_source_i(cli_a_source), .cli_a_address_i(cli_a_address), .cli_a_mask_i(cli_a_mask),
      .cli_a_data_i(cli_a_data), .cli_a_corrupt_i(cli_a_corrupt),
      .mgr_a_valid_o(mgr_a_valid), .mgr_a_ready_i(mgr_a_ready),
      .mgr_a_opcode_o(mgr_a_opcode), .mgr_a_param_o(mgr_a_param), .mgr_a_size_o(mgr_a_size),
      .mgr_a_source_o(mgr_a_source), .mgr_a_address_o(mgr_a_address), .mgr_a_mask_o(mgr_a_mask),
      .mgr_a_data_o(mgr_a_data), .mgr_a_corrupt_o(mgr_a_corrupt),
      .mgr_d_valid_i(mgr_d_valid), .mgr_d_ready_o(mgr_d_ready),
      .mgr_d_opcode_i(mgr_d_opcode), .mgr_d_param_i(mgr_d_param), .mgr_d_size_i(mgr_d_size),
      .mgr_d_source_i(mgr_d_source), .mgr_d_sink_i(mgr_d_sink), .mgr_d_denied_i(mgr_d_denied),
      .mgr_d_data_i(mgr_d_data), .mgr_d_corrupt_i(mgr_d_corrupt),
      .cli_d_valid_o(cli_d_valid), .cli_d_ready_i(cli_d_ready),
      .cli_d_opcode_o(cli_d_opcode), .cli_d_param_o(cli_d_param), .cli_d_size_o(cli_d_size),
      .cli_d_source_o(cli_d_source), .cli_d_sink_o(cli_d_sink), .cli_d_denied_o(cli_d_denied),
      .cli_d_corrupt_o(cli_d_corrupt), .cli_d_data_o(cli_d_data)
`ifdef TL_CLIENT_ARBITER_STATS_EN
      , .stat_grants_o(stat_grants)
`endif
   );
   always #5 clk = ~clk;
   task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      total++;
      assert (obs === exp) passed++;
      else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
   endtask
   task automatic tick();
      @(posedge clk);
      #1;
   endtask
   task automatic set_cli(input int i, input logic [2:0] op, input logic [3:0] sz,
                          input logic [3:0] src, input logic [63:0] dat);
      cli_a_opcode[i*3 +: 3]    = op;
      cli_a_size[i*4 +: 4]      = sz;
      cli_a_source[i*SW +: SW]  = src;
      cli_a_address[i*AW +: AW] = 64'h1000 + 64'(i);
      cli_a_mask[i*MW +: MW]    = '1;
      cli_a_data[i*DW +: DW]    = dat;
   endtask
   initial begin
      // Reset state, all four clients requesting Gets while still in reset
      for (int i = 0; i < N; i++) set_cli(i, 3'd4, 4'd3, 4'(i + 8), 64'(i));
      cli_a_valid = 4'b1111;
      tick();
      chk("rst_valid", mgr_a_valid, 0);
      chk("rst_ready", cli_a_ready, 4'b0000);
      chk("rst_source", mgr_a_source, 0);
      rst = 1'b0;
      #1 chk("rr_rdy0", cli_a_ready, 4'b0001);
      tick();
      chk("rr_lat", mgr_a_valid, 1);
      chk("rr_src0", mgr_a_source, 6'h08);
      chk("rr_addr0", mgr_a_address, 64'h1000);
      cli_a_valid = 4'b1110;
      #1 chk("rr_rdy1", cli_a_ready, 4'b0010);
      tick();
      chk("rr_src1", mgr_a_source, 6'h19);
      cli_a_valid = 4'b1100;
      tick();
      chk("rr_src2", mgr_a_source, 6'h2A);
      cli_a_valid = 4'b1000;
      tick();
      chk("rr_src3", mgr_a_source, 6'h3B);
      cli_a_valid = 4'b0000;
      tick();
      chk("rr_empty", mgr_a_valid, 0);
      // Eight-beat PutFullData from client 1 must not be interleaved by client 2's Get
      set_cli(1, 3'd0, 4'd6, 4'd9, 64'd0);
      set_cli(2, 3'd4, 4'd3, 4'd10, 64'hAA);
      cli_a_valid = 4'b0110;
      for (int b = 0; b < 8; b++) begin
         cli_a_data[DW +: DW] = 64'(b);
         #1 chk("put_rdy", cli_a_ready, 4'b0010);
         tick();
         chk("put_src", mgr_a_source, 6'h19);
         chk("put_dat", mgr_a_data, 128'(b));
      end
      cli_a_valid = 4'b0100;
      #1 chk("put_next_rdy", cli_a_ready, 4'b0100);
      tick();
      chk("put_next_src", mgr_a_source, 6'h2A);
      chk("put_next_op", mgr_a_opcode, 3'd4);
      cli_a_valid = 4'b0000;
      tick();
      chk("put_empty", mgr_a_valid, 0);
      // Backpressure: slot full with manager stalled for three cycles
      mgr_a_ready = 1'b0;
      set_cli(3, 3'd4, 4'd3, 4'd11, 64'h33);
      set_cli(0, 3'd4, 4'd3, 4'd8, 64'h00);
      cli_a_valid = 4'b1000;
      #1 chk("bp_rdy_first", cli_a_ready, 4'b1000);
      tick();
      cli_a_data[3*DW +: DW] = 64'h34;
      cli_a_valid = 4'b1001;
      for (int c = 0; c < 3; c++) begin
         #1 chk("bp_rdy_stall", cli_a_ready, 4'b0000);
         chk("bp_valid", mgr_a_valid, 1);
         chk("bp_dat", mgr_a_data, 64'h33);
         chk("bp_src", mgr_a_source, 6'h3B);
         tick();
      end
      mgr_a_ready = 1'b1;
      #1 chk("bp_rdy_resume", cli_a_ready, 4'b0001);
      tick();
      chk("bp_src_c0", mgr_a_source, 6'h08);
      chk("bp_dat_c0", mgr_a_data, 64'h00);
      cli_a_valid = 4'b1000;
      tick();
      chk("bp_src_c3", mgr_a_source, 6'h3B);
      chk("bp_dat_c3", mgr_a_data, 64'h34);
      cli_a_valid = 4'b0000;
      tick();
      chk("bp_empty", mgr_a_valid, 0);
      // D routing by client-index bits of the source
      mgr_d_valid = 1'b1;
      mgr_d_source = 6'h25;
      mgr_d_data = 64'hDEAD_BEEF;
      mgr_d_opcode = 3'd1;
      cli_d_ready = 4'b1011;
      #1 chk("d_valid", cli_d_valid, 4'b0100);
      chk("d_source", cli_d_source, 4'h5);
      chk("d_ready_low", mgr_d_ready, 0);
      chk("d_data", cli_d_data, 64'hDEAD_BEEF);
      chk("d_opcode", cli_d_opcode, 3'd1);
      cli_d_ready = 4'b0100;
      #1 chk("d_ready_high", mgr_d_ready, 1);
      mgr_d_valid = 1'b0;
      #1 chk("d_idle", cli_d_valid, 4'b0000);
      // Reset in the middle of a burst, then priority restarts at client 0
      set_cli(1, 3'd0, 4'd6, 4'd9, 64'h77);
      cli_a_valid = 4'b0010;
      for (int b = 0; b < 4; b++) tick();
      chk("mid_valid", mgr_a_valid, 1);
      rst = 1'b1;
      #1 chk("mid_rst_valid", mgr_a_valid, 0);
      chk("mid_rst_ready", cli_a_ready, 4'b0000);
      chk("mid_rst_data", mgr_a_data, 0);
      cli_a_valid = 4'b1001;
      tick();
      chk("mid_rst_ready2", cli_a_ready, 4'b0000);
      rst = 1'b0;
      #1 chk("post_rdy", cli_a_ready, 4'b0001);
      tick();
      chk("post_src0", mgr_a_source, 6'h08);
      cli_a_valid = 4'b1000;
      tick();
      chk("post_src3", mgr_a_source, 6'h3B);
      cli_a_valid = 4'b0000;
      tick();
      chk("post_empty", mgr_a_valid, 0);
`ifdef TL_CLIENT_ARBITER_STATS_EN
      rst = 1'b1;
      tick();
      rst = 1'b0;
      cli_a_valid = 4'b1000;
      for (int b = 0; b < 3; b++) tick();
      cli_a_valid = 4'b0000;
      tick();
      chk("stats", stat_grants, {32'd3, 96'd0});
`endif
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end
endmodule
